// File: rtl/md_ctrl.sv
// Issue/stall controller for the E-stage HI/LO multiply/divide unit.
// Tracks the unit's fixed latency locally so D-stage stall needs no handshake.
module md_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic        e_flush,
  input  logic        d_md_use,
  output logic [3:0]  hilo_type,
  output logic        md_busy,
  output logic        stall_d,
  output logic [3:0]  wait_left,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt,
  output logic        proto_err
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [3:0] MulLat = 4'(MUL_LAT);
  localparam logic [3:0] DivLat = 4'(DIV_LAT);

  state_e      state_q, state_d;
  logic [3:0]  wait_left_q, wait_left_d;
  logic [31:0] stall_cnt_q, issue_cnt_q;
  logic        proto_err_q;

  logic op_start, op_move, op_mul, go, start, blocked;

  // Op decode; codes 0 and 9-15 are treated as no operation.
  always_comb begin
    op_start = (e_op >= 4'd1) && (e_op <= 4'd4);
    op_move  = (e_op >= 4'd5) && (e_op <= 4'd8);
    op_mul   = (e_op == 4'd1) || (e_op == 4'd2);
    go       = e_valid && !e_flush && (op_start || op_move);
    start    = go && op_start && (wait_left_q == 4'd0);
    blocked  = go && op_start && (wait_left_q != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_left_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      wait_left_q <= wait_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_left_d = wait_left_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = op_mul ? StMul : StDiv;
          wait_left_d = op_mul ? MulLat : DivLat;
        end
      end
      StMul, StDiv: begin
        // Leave on the 1->0 edge so a new start is accepted the very next cycle.
        if (wait_left_q <= 4'd1) begin
          state_d     = StIdle;
          wait_left_d = 4'd0;
        end else begin
          wait_left_d = wait_left_q - 4'd1;
        end
      end
      default: begin
        state_d     = StIdle;
        wait_left_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    hilo_type = (go && !blocked) ? e_op : 4'd0;
    md_busy   = start || (wait_left_q != 4'd0);
    stall_d   = d_md_use && md_busy;
    wait_left = wait_left_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      issue_cnt_q <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      if (stall_d) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (start) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      // Only reachable if the pipeline ignored stall_d; never cleared except by reset.
      if (blocked) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: a cycle model pushes expected outputs per
// driven cycle, which are popped and compared mid-cycle.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic        e_flush;
  logic        d_md_use;
  logic [3:0]  hilo_type;
  logic        md_busy;
  logic        stall_d;
  logic [3:0]  wait_left;
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;
  logic        proto_err;

  md_ctrl #(
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_op     (e_op),
    .e_flush  (e_flush),
    .d_md_use (d_md_use),
    .hilo_type(hilo_type),
    .md_busy  (md_busy),
    .stall_d  (stall_d),
    .wait_left(wait_left),
    .stall_cnt(stall_cnt),
    .issue_cnt(issue_cnt),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  hilo;
    logic        busy;
    logic        stall;
    logic [3:0]  left;
    logic [31:0] scnt;
    logic [31:0] icnt;
    logic        perr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, advanced at each rising edge from the previous cycle.
  int unsigned m_left  = 0;
  int unsigned m_scnt  = 0;
  int unsigned m_icnt  = 0;
  bit          m_perr  = 0;
  bit          p_rst   = 1;
  bit          p_start = 0;
  bit          p_stall = 0;
  bit          p_perr  = 0;
  int unsigned p_lat   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive after the edge, compare at the falling edge.
  task automatic cyc(input logic v, input logic [3:0] op, input logic fl, input logic du,
                     input logic rst);
    exp_t e;
    exp_t o;
    bit is_start, go;
    @(posedge clk);
    if (p_rst) begin
      m_left = 0; m_scnt = 0; m_icnt = 0; m_perr = 0;
    end else begin
      if (p_start) m_left = p_lat;
      else if (m_left > 0) m_left = m_left - 1;
      if (p_stall) m_scnt = m_scnt + 1;
      if (p_start) m_icnt = m_icnt + 1;
      if (p_perr) m_perr = 1;
    end
    #1;
    reset = rst; e_valid = v; e_op = op; e_flush = fl; d_md_use = du;
    is_start = (op >= 1) && (op <= 4);
    go       = v && !fl && (op >= 1) && (op <= 8);
    e.hilo  = (go && !(is_start && m_left != 0)) ? op : 4'd0;
    p_start = go && is_start && (m_left == 0);
    e.busy  = p_start || (m_left != 0);
    e.stall = du && e.busy;
    e.left  = 4'(m_left);
    e.scnt  = m_scnt;
    e.icnt  = m_icnt;
    e.perr  = m_perr;
    p_stall = e.stall;
    p_perr  = go && is_start && (m_left != 0);
    p_lat   = (op <= 2) ? 5 : 10;
    p_rst   = rst;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    check_eq("hilo_type", {28'd0, hilo_type}, {28'd0, o.hilo});
    check_eq("md_busy", {31'd0, md_busy}, {31'd0, o.busy});
    check_eq("stall_d", {31'd0, stall_d}, {31'd0, o.stall});
    check_eq("wait_left", {28'd0, wait_left}, {28'd0, o.left});
    check_eq("stall_cnt", stall_cnt, o.scnt);
    check_eq("issue_cnt", issue_cnt, o.icnt);
    check_eq("proto_err", {31'd0, proto_err}, {31'd0, o.perr});
  endtask

  task automatic idle(input logic du);
    cyc(1'b0, 4'd0, 1'b0, du, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_op = 4'd0; e_flush = 1'b0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    idle(1'b0);
    check_eq("rst_busy", {31'd0, md_busy}, 32'd0);
    check_eq("rst_left", {28'd0, wait_left}, 32'd0);

    // mult with mflo held in D
    do_reset();
    cyc(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    check_eq("t1_hilo", {28'd0, hilo_type}, 32'd1);
    check_eq("t1_stall0", {31'd0, stall_d}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      idle(1'b1);
      check_eq("t1_left", {28'd0, wait_left}, 32'(6 - i));
      check_eq("t1_stall", {31'd0, stall_d}, 32'd1);
    end
    idle(1'b1);
    check_eq("t1_release", {31'd0, stall_d}, 32'd0);
    check_eq("t1_scnt", stall_cnt, 32'd6);
    check_eq("t1_icnt", issue_cnt, 32'd1);

    // divu, no D use
    do_reset();
    cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    check_eq("t2_busy0", {31'd0, md_busy}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      idle(1'b0);
      if (i == 1) check_eq("t2_left1", {28'd0, wait_left}, 32'd10);
      check_eq("t2_busy", {31'd0, md_busy}, 32'd1);
    end
    idle(1'b0);
    check_eq("t2_left11", {28'd0, wait_left}, 32'd0);
    check_eq("t2_busy11", {31'd0, md_busy}, 32'd0);
    check_eq("t2_scnt", stall_cnt, 32'd0);

    // Flushed mult, then mthi; out-of-range op
    do_reset();
    cyc(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    check_eq("t3_hilo", {28'd0, hilo_type}, 32'd0);
    check_eq("t3_busy", {31'd0, md_busy}, 32'd0);
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    check_eq("t3_mthi", {28'd0, hilo_type}, 32'd8);
    check_eq("t3_icnt", issue_cnt, 32'd0);
    cyc(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    check_eq("t3_op12", {28'd0, hilo_type}, 32'd0);

    // Start op forced into E while dividing
    do_reset();
    cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_hilo", {28'd0, hilo_type}, 32'd0);
    check_eq("t4_left3", {28'd0, wait_left}, 32'd8);
    idle(1'b0);
    check_eq("t4_perr", {31'd0, proto_err}, 32'd1);
    check_eq("t4_left4", {28'd0, wait_left}, 32'd7);
    cyc(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);  // flush while busy does not cancel
    check_eq("t4_left5", {28'd0, wait_left}, 32'd6);
    for (int i = 0; i < 8; i++) idle(1'b0);
    check_eq("t4_sticky", {31'd0, proto_err}, 32'd1);
    check_eq("t4_icnt", issue_cnt, 32'd1);

    // Reset mid-operation
    do_reset();
    cyc(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    check_eq("t5_left", {28'd0, wait_left}, 32'd0);
    check_eq("t5_busy", {31'd0, md_busy}, 32'd0);
    check_eq("t5_icnt", issue_cnt, 32'd0);
    check_eq("t5_scnt", stall_cnt, 32'd0);

    // Back-to-back mult/multu
    do_reset();
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    check_eq("t6_hilo", {28'd0, hilo_type}, 32'd2);
    idle(1'b0);
    check_eq("t6_left", {28'd0, wait_left}, 32'd5);
    check_eq("t6_icnt", issue_cnt, 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
